// File: rtl/gmii_frame_rx_if.sv
// Bundle for gmii_frame_rx: GMII byte stream in, delineated frame bytes and per-frame status out.
// master = stream source / status consumer, slave = the delineator.
interface gmii_frame_rx_if;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        frame_done;
    logic        frame_ok;
    logic [10:0] frame_len;
    logic [15:0] drop_cnt;

    modport master (
        output gmii_rx_dv, gmii_rxd,
        input  out_valid, out_data, out_sof, frame_done, frame_ok, frame_len, drop_cnt
    );

    modport slave (
        input  gmii_rx_dv, gmii_rxd,
        output out_valid, out_data, out_sof, frame_done, frame_ok, frame_len, drop_cnt
    );
endinterface

// File: rtl/gmii_frame_rx.sv
// GMII receive frame delineator: strips preamble/SFD, hides the FCS behind a 4-byte delay line and
// reports length/good per frame. Define GMII_RX_CRC_CHECK_EN to include the CRC-32 check on frame_ok.
module gmii_frame_rx #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic           clk,
    input  logic           rst,
    gmii_frame_rx_if.slave rx_if
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_DATA     = 3'd2,
        S_TRUNC    = 3'd3,
        S_DROP     = 3'd4
    } state_t;

    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [2:0]  PRE_MAX     = 3'd7;
    localparam logic [10:0] LEN_SAT     = 11'h7FF;
    localparam logic [10:0] DLY_DEPTH   = 11'd4;
    localparam logic [15:0] DROP_SAT    = 16'hFFFF;
    localparam logic [10:0] MIN_LEN_C   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_C   = 11'(MAX_LEN);
    localparam logic [10:0] TRUNC_LEN_C = 11'(MAX_LEN + 1);

    logic            dv_s;
    logic [7:0]      rxd_s;
    logic            rise_s;
    logic            sfd_hit_s;
    logic            len_ok_s;
    logic            crc_ok_s;
    logic [10:0]     len_inc_s;
    logic [15:0]     drop_inc_s;

    state_t          state_q, state_d;
    logic            dv_prev_q;
    logic [2:0]      pcnt_q, pcnt_d;
    logic [10:0]     len_q, len_d;
    logic [3:0][7:0] dly_q, dly_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_sof_q, out_sof_d;
    logic            frame_done_q, frame_done_d;
    logic            frame_ok_q, frame_ok_d;
    logic [10:0]     frame_len_q, frame_len_d;

    assign dv_s       = rx_if.gmii_rx_dv;
    assign rxd_s      = rx_if.gmii_rxd;
    assign rise_s     = dv_s & ~dv_prev_q;
    assign sfd_hit_s  = (state_q == S_PREAMBLE) && dv_s && (rxd_s == SFD_BYTE) && (pcnt_q != 3'd0);
    assign len_inc_s  = (len_q == LEN_SAT) ? len_q : (len_q + 11'd1);
    assign drop_inc_s = (drop_cnt_q == DROP_SAT) ? drop_cnt_q : (drop_cnt_q + 16'd1);
    assign len_ok_s   = (len_q >= MIN_LEN_C) && (len_q <= MAX_LEN_C);

`ifdef GMII_RX_CRC_CHECK_EN
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    logic [31:0] crc_q, crc_d;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data_in);
        logic [31:0] c;
        c = crc_in ^ {24'h00_0000, data_in};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // CRC restarts at the SFD and absorbs every byte after it, FCS included
    always_comb begin
        if (sfd_hit_s) begin
            crc_d = CRC_INIT;
        end else if ((state_q == S_DATA) && dv_s) begin
            crc_d = crc32_byte(crc_q, rxd_s);
        end else begin
            crc_d = crc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_ok_s = (crc_q == CRC_RESIDUE);
`else
    assign crc_ok_s = 1'b1;
`endif

    // dv_prev resets high so a frame already in flight at reset release lands in DROP uncounted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dv_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            dv_prev_q <= dv_s;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rise_s) begin
                    state_d = (rxd_s == PRE_BYTE) ? S_PREAMBLE : S_DROP;
                end else if (dv_s) begin
                    state_d = S_DROP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREAMBLE: begin
                if (!dv_s) begin
                    state_d = S_IDLE;
                end else if (sfd_hit_s) begin
                    state_d = S_DATA;
                end else if ((rxd_s == PRE_BYTE) && (pcnt_q < PRE_MAX)) begin
                    state_d = S_PREAMBLE;
                end else begin
                    state_d = S_DROP;
                end
            end
            S_DATA: begin
                if (!dv_s) begin
                    state_d = S_IDLE;
                end else if (len_inc_s == TRUNC_LEN_C) begin
                    state_d = S_TRUNC;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_TRUNC, S_DROP: begin
                state_d = dv_s ? state_q : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The byte that pushes the length past MAX_LEN is swallowed: output stops at MAX_LEN-4 bytes
    always_comb begin
        pcnt_d       = pcnt_q;
        len_d        = len_q;
        dly_d        = dly_q;
        drop_cnt_d   = drop_cnt_q;
        out_valid_d  = 1'b0;
        out_data_d   = 8'h00;
        out_sof_d    = 1'b0;
        frame_done_d = 1'b0;
        frame_ok_d   = frame_ok_q;
        frame_len_d  = frame_len_q;
        case (state_q)
            S_IDLE: begin
                if (rise_s && (rxd_s == PRE_BYTE)) begin
                    pcnt_d = 3'd1;
                end else if (rise_s) begin
                    drop_cnt_d = drop_inc_s;
                end else begin
                    pcnt_d = pcnt_q;
                end
            end
            S_PREAMBLE: begin
                if (!dv_s) begin
                    drop_cnt_d = drop_inc_s;
                end else if (sfd_hit_s) begin
                    len_d = 11'd0;
                    dly_d = '0;
                end else if ((rxd_s == PRE_BYTE) && (pcnt_q < PRE_MAX)) begin
                    pcnt_d = pcnt_q + 3'd1;
                end else begin
                    drop_cnt_d = drop_inc_s;
                end
            end
            S_DATA: begin
                if (dv_s) begin
                    len_d = len_inc_s;
                    dly_d = {dly_q[2:0], rxd_s};
                    if ((len_q >= DLY_DEPTH) && (len_inc_s != TRUNC_LEN_C)) begin
                        out_valid_d = 1'b1;
                        out_data_d  = dly_q[3];
                        out_sof_d   = (len_q == DLY_DEPTH);
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end else begin
                    frame_done_d = 1'b1;
                    frame_ok_d   = len_ok_s && crc_ok_s;
                    frame_len_d  = len_q;
                    dly_d        = '0;
                end
            end
            S_TRUNC: begin
                if (dv_s) begin
                    len_d = len_inc_s;
                end else begin
                    frame_done_d = 1'b1;
                    frame_ok_d   = 1'b0;
                    frame_len_d  = len_q;
                end
            end
            S_DROP: begin
                pcnt_d = pcnt_q;
            end
            default: begin
                pcnt_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q       <= 3'd0;
            len_q        <= 11'd0;
            dly_q        <= '0;
            drop_cnt_q   <= 16'd0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_sof_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_len_q  <= 11'd0;
        end else begin
            pcnt_q       <= pcnt_d;
            len_q        <= len_d;
            dly_q        <= dly_d;
            drop_cnt_q   <= drop_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sof_q    <= out_sof_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            frame_len_q  <= frame_len_d;
        end
    end

    assign rx_if.out_valid  = out_valid_q;
    assign rx_if.out_data   = out_data_q;
    assign rx_if.out_sof    = out_sof_q;
    assign rx_if.frame_done = frame_done_q;
    assign rx_if.frame_ok   = frame_ok_q;
    assign rx_if.frame_len  = frame_len_q;
    assign rx_if.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_gmii_frame_rx.sv
// Bench for gmii_frame_rx: directed frame table, reset-mid-frame sequence and random frames,
// all scored against a frame-level reference model.
module tb_gmii_frame_rx;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
`ifdef GMII_RX_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    typedef struct {
        int         pre_len;
        logic [7:0] pre_bad;
        int         pay_len;
        logic [7:0] fcs_xor;
        int         gap;
        bit         exp_done;
        bit         exp_ok;
        int         exp_len;
        int         exp_nout;
        int         exp_drop;
    } vec_t;

    typedef struct {
        int len;
        bit ok;
        int nout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gmii_frame_rx_if bus();

    gmii_frame_rx #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .rst   (rst),
        .rx_if (bus)
    );

    always #4 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         model_drops = 0;
    int         done_cnt = 0;
    int         last_len = 0;
    bit         last_ok = 1'b0;
    int         last_nout = 0;
    logic [7:0] tx_q[$];
    logic [7:0] crc_buf[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_bytes[$];
    exp_t       exp_q[$];
    exp_t       mon_e;
    int         mon_mism;
    vec_t       vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Ethernet FCS value (already inverted) over crc_buf, one bit at a time
    function automatic logic [31:0] crc_calc();
        logic [31:0] r;
        logic        fb;
        r = 32'hFFFF_FFFF;
        foreach (crc_buf[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[0] ^ crc_buf[i][b];
                r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'h0000_0000);
            end
        end
        return ~r;
    endfunction

    task automatic build_frame(input int pre_len, input logic [7:0] pre_bad, input int pay_len,
                               input logic [7:0] fcs_xor, input bit rand_data);
        logic [31:0] fcs;
        logic [7:0]  b;
        tx_q.delete();
        crc_buf.delete();
        for (int i = 0; i < pre_len; i++) tx_q.push_back(8'h55);
        tx_q.push_back((pre_bad != 8'h00) ? pre_bad : 8'hD5);
        for (int i = 0; i < pay_len; i++) begin
            b = rand_data ? 8'($urandom) : 8'(i);
            tx_q.push_back(b);
            crc_buf.push_back(b);
        end
        fcs = crc_calc();
        for (int i = 0; i < 4; i++) begin
            b = fcs[8*i +: 8];
            if (i == 3) b = b ^ fcs_xor;
            tx_q.push_back(b);
        end
    endtask

    task automatic model_stream();
        int          k;
        int          n;
        int          body_len;
        int          nout;
        logic [31:0] c;
        bit          fcs_ok;
        exp_t        e;
        n = tx_q.size();
        k = 0;
        while ((k < n) && (tx_q[k] == 8'h55)) k++;
        if ((k == 0) || (k > 7) || (k >= n) || (tx_q[k] != 8'hD5)) begin
            model_drops++;
        end else begin
            body_len = n - k - 1;
            nout = ((body_len > MAX_LEN) ? MAX_LEN : body_len) - 4;
            if (nout < 0) nout = 0;
            for (int i = 0; i < nout; i++) exp_bytes.push_back(tx_q[k + 1 + i]);
            fcs_ok = 1'b0;
            if (body_len >= 4) begin
                crc_buf.delete();
                for (int i = 0; i < body_len - 4; i++) crc_buf.push_back(tx_q[k + 1 + i]);
                c = crc_calc();
                fcs_ok = 1'b1;
                for (int i = 0; i < 4; i++)
                    if (tx_q[k + 1 + body_len - 4 + i] != c[8*i +: 8]) fcs_ok = 1'b0;
            end
            e.len  = (body_len > 2047) ? 2047 : body_len;
            e.ok   = (body_len >= MIN_LEN) && (body_len <= MAX_LEN) && (fcs_ok || !CRC_EN);
            e.nout = nout;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_stream(input int gap);
        model_stream();
        foreach (tx_q[i]) begin
            @(negedge clk);
            bus.gmii_rx_dv = 1'b1;
            bus.gmii_rxd   = tx_q[i];
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.gmii_rx_dv = 1'b0;
            bus.gmii_rxd   = 8'h00;
        end
    endtask

    // Scoreboard: collect output bytes per frame and score them at each frame_done
    always @(negedge clk) begin
        if (rst) begin
            got_q.delete();
        end else begin
            if (bus.out_valid) begin
                check("out_sof", bus.out_sof, got_q.size() == 0);
                got_q.push_back(bus.out_data);
            end
            if (bus.frame_done) begin
                check("valid_with_done", bus.out_valid, 0);
                check("done_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("frame_len", bus.frame_len, mon_e.len);
                    check("frame_ok", bus.frame_ok, mon_e.ok);
                    check("frame_nbytes", got_q.size(), mon_e.nout);
                    mon_mism = 0;
                    for (int i = 0; i < mon_e.nout; i++) begin
                        if ((i >= got_q.size()) || (got_q[i] !== exp_bytes[0])) mon_mism++;
                        void'(exp_bytes.pop_front());
                    end
                    check("frame_data", mon_mism, 0);
                end
                done_cnt++;
                last_len  = int'(bus.frame_len);
                last_ok   = bus.frame_ok;
                last_nout = got_q.size();
                got_q.delete();
            end
        end
    end

    initial begin
        int d0;
        int dr0;
        int pre;
        logic [7:0] bad;
        int plen;
        logic [7:0] fx;

        vecs[0]  = '{7, 8'h00,   60, 8'h00, 12, 1'b1, 1'b1,     64,   60, 0};
        vecs[1]  = '{7, 8'h00,   60, 8'h01, 12, 1'b1, !CRC_EN,  64,   60, 0};
        vecs[2]  = '{7, 8'h00,   16, 8'h00, 12, 1'b1, 1'b0,     20,   16, 0};
        vecs[3]  = '{2, 8'hAA,   60, 8'h00, 12, 1'b0, 1'b0,      0,    0, 1};
        vecs[4]  = '{7, 8'h00,   60, 8'h00, 12, 1'b1, 1'b1,     64,   60, 0};
        vecs[5]  = '{7, 8'h00, 1596, 8'h00, 12, 1'b1, 1'b0,   1600, 1514, 0};
        vecs[6]  = '{1, 8'h00,   60, 8'h00,  1, 1'b1, 1'b1,     64,   60, 0};
        vecs[7]  = '{7, 8'h00, 1514, 8'h00,  3, 1'b1, 1'b1,   1518, 1514, 0};
        vecs[8]  = '{7, 8'h00, 1515, 8'h00,  3, 1'b1, 1'b0,   1519, 1514, 0};
        vecs[9]  = '{7, 8'h00,   59, 8'h00,  3, 1'b1, 1'b0,     63,   59, 0};
        vecs[10] = '{7, 8'h00,    0, 8'h00,  3, 1'b1, 1'b0,      4,    0, 0};
        vecs[11] = '{8, 8'h00,   60, 8'h00,  3, 1'b0, 1'b0,      0,    0, 1};
        vecs[12] = '{0, 8'h00,   60, 8'h00,  3, 1'b0, 1'b0,      0,    0, 1};
        vecs[13] = '{7, 8'h00, 2096, 8'h00,  3, 1'b1, 1'b0,   2047, 1514, 0};

        // reset values, with a frame already running when reset is released
        bus.gmii_rx_dv = 1'b1;
        bus.gmii_rxd   = 8'h55;
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_sof", bus.out_sof, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_frame_ok", bus.frame_ok, 0);
        check("rst_frame_len", bus.frame_len, 0);
        check("rst_drop_cnt", bus.drop_cnt, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        bus.gmii_rx_dv = 1'b0;
        repeat (3) @(negedge clk);
        check("release_busy_drop", bus.drop_cnt, 0);
        check("release_busy_done", done_cnt, 0);

        for (int v = 0; v < 14; v++) begin
            d0  = done_cnt;
            dr0 = int'(bus.drop_cnt);
            build_frame(vecs[v].pre_len, vecs[v].pre_bad, vecs[v].pay_len, vecs[v].fcs_xor, 1'b0);
            send_stream(vecs[v].gap);
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_done", v), done_cnt - d0, vecs[v].exp_done);
            if (vecs[v].exp_done) begin
                check($sformatf("vec%0d_ok", v), last_ok, vecs[v].exp_ok);
                check($sformatf("vec%0d_len", v), last_len, vecs[v].exp_len);
                check($sformatf("vec%0d_nout", v), last_nout, vecs[v].exp_nout);
            end
            check($sformatf("vec%0d_drop", v), int'(bus.drop_cnt) - dr0, vecs[v].exp_drop);
        end

        // reset pulse on the 30th data byte (index 7 + 1 + 29)
        build_frame(7, 8'h00, 60, 8'h00, 1'b0);
        d0 = done_cnt;
        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            bus.gmii_rx_dv = 1'b1;
            bus.gmii_rxd   = tx_q[i];
        end
        @(negedge clk);
        bus.gmii_rxd = tx_q[37];
        check("pre_rst_valid", bus.out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_data", bus.out_data, 0);
        check("midrst_frame_len", bus.frame_len, 0);
        check("midrst_frame_ok", bus.frame_ok, 0);
        check("midrst_drop_cnt", bus.drop_cnt, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        bus.gmii_rxd = tx_q[38];
        for (int i = 39; i < tx_q.size(); i++) begin
            @(negedge clk);
            bus.gmii_rxd = tx_q[i];
        end
        @(negedge clk);
        bus.gmii_rx_dv = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_drop_after", bus.drop_cnt, 0);
        check("midrst_no_bytes", got_q.size(), 0);
        model_drops = 0;

        build_frame(7, 8'h00, 60, 8'h00, 1'b0);
        send_stream(3);
        repeat (3) @(negedge clk);
        check("post_rst_done", done_cnt - d0, 1);
        check("post_rst_ok", last_ok, 1);
        check("post_rst_len", last_len, 64);

        // randomized frames, back-to-back gaps down to one cycle
        for (int f = 0; f < 40; f++) begin
            pre  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : 7;
            bad  = ($urandom_range(0, 9) == 0) ? 8'h5A : 8'h00;
            plen = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1508, 1522)) : int'($urandom_range(0, 90));
            fx   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            build_frame(pre, bad, plen, fx, 1'b1);
            send_stream(int'($urandom_range(1, 4)));
        end

        for (int i = 0; (i < 200) && (exp_q.size() != 0); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("frames_pending", exp_q.size(), 0);
        check("final_drop_cnt", bus.drop_cnt, model_drops);
        check("final_no_stray_bytes", got_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
